// File: rtl/mmio_uart_tx.sv
// ============================================================================
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with a TX byte FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

package mmio_uart_tx_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] value;
        logic [1:0]      width;
        logic            enable;
    } mem_write_control_t;
endpackage

module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] base_addr     = 32'h0001_0000,
    parameter int          fifo_depth    = 8,
    parameter logic [15:0] reset_divisor = 16'd868
) (
    input  logic               clock,
    input  logic               reset_n,
    input  mem_write_control_t io_control,
    output logic [XLEN-1:0]    r_data,
    output logic               tx
);

    localparam int PTR_W = $clog2(fifo_depth);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [29:0] c_word_txdata  = base_addr[31:2];
    localparam logic [29:0] c_word_status  = base_addr[31:2] + 30'd1;
    localparam logic [29:0] c_word_divisor = base_addr[31:2] + 30'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [15:0]      baud_q, baud_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [15:0]      divisor_q, divisor_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]  r_data_q, r_data_d;
    logic [7:0]       fifo_mem_q [fifo_depth];

    logic        w_sel_txdata, w_sel_status, w_sel_divisor;
    logic        w_empty, w_full, w_pop, w_wr_req, w_accept;
    logic [15:0] w_reload;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_sel_txdata  = (io_control.addr[31:2] == c_word_txdata);
    assign w_sel_status  = (io_control.addr[31:2] == c_word_status);
    assign w_sel_divisor = (io_control.addr[31:2] == c_word_divisor);

    // A stored divisor of 0 is treated as 1, so the reload value is never negative.
    assign w_reload = (divisor_q == 16'd0) ? 16'd0 : (divisor_q - 16'd1);

    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == CNT_W'(fifo_depth));
    assign w_pop    = !w_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && (baud_q == 16'd0)));
    assign w_wr_req = io_control.enable && w_sel_txdata;
    assign w_accept = w_wr_req && (!w_full || w_pop);

    assign w_unused = ^{io_control.width, io_control.addr[1:0], io_control.value[31:16]};

    always_comb begin
        w_status       = '0;
        w_status[0]    = w_full;
        w_status[1]    = w_empty;
        w_status[2]    = (state_q != ST_IDLE);
        w_status[3]    = overflow_q;
        w_status[12:8] = 5'(count_q);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        divisor_d  = divisor_q;
        r_data_d   = '0;

        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (w_accept && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_accept && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // Setting overflow takes priority over a same-cycle clear.
        if (w_wr_req && !w_accept) begin
            overflow_d = 1'b1;
        end else if (io_control.enable && w_sel_status && io_control.value[3]) begin
            overflow_d = 1'b0;
        end

        if (io_control.enable && w_sel_divisor) begin
            divisor_d = io_control.value[15:0];
        end

        if (w_sel_status) begin
            r_data_d = w_status;
        end else if (w_sel_divisor) begin
            r_data_d = {16'd0, divisor_q};
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        shift_d   = shift_q;
        tx_d      = tx_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (w_pop) begin
                    state_d = ST_START;
                    shift_d = fifo_mem_q[rd_ptr_q];
                    baud_d  = w_reload;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_q == 16'd0) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    baud_d    = w_reload;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = w_reload;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_q == 16'd0) begin
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (w_pop) begin
                        state_d = ST_START;
                        shift_d = fifo_mem_q[rd_ptr_q];
                        baud_d  = w_reload;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= 3'd0;
            baud_q     <= 16'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            divisor_q  <= reset_divisor;
            overflow_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            r_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            divisor_q  <= divisor_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            r_data_q   <= r_data_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            fifo_mem_q[wr_ptr_q] <= io_control.value[7:0];
        end
    end

    assign r_data = r_data_q;
    assign tx     = tx_q;

endmodule

`default_nettype wire

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter base_addr, default 32'h00010000, byte address of register 0 of this peripheral.
REQ-002 Parameter fifo_depth, default 8, TX FIFO entries (power of two, 2..16).
REQ-003 Parameter reset_divisor, default 16'd868, bit period in clocks after reset.
REQ-004 Port clock  input  1  rising-edge clock.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port io_control  input  mem_write_control_t  addr, value, width and enable from the data-memory stage.
REQ-007 Port r_data  output  XLEN  registered read data for io_control.addr, returned on the memory stage's MMIO read-data input.
REQ-008 Port tx  output  1  serial line, idle high.

Function
REQ-009 Register map, word offsets from base_addr:
- 0x0 TXDATA: write-only; reads return 0.
- 0x4 STATUS: read; bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[12:8] FIFO count, all other bits 0.
- 0x8 DIVISOR: read/write, bits[15:0]; upper bits read 0.
REQ-010 Address decode: compare io_control.addr[31:2] only; addr[1:0] and width are ignored except as stated below.
REQ-011 Write to TXDATA with enable=1 enqueues value[7:0], for any width.
REQ-012 Write acceptance: accepted when count<fifo_depth, or when the FSM pops in the same cycle; otherwise the byte is dropped, FIFO is unchanged, and overflow is set.
REQ-013 Write to STATUS with value[3]=1 clears overflow. If the same cycle also sets overflow, set wins.
REQ-014 Write to DIVISOR stores value[15:0]. A stored value of 0 behaves as 1.
REQ-015 Writes to unmapped offsets are ignored.
REQ-016 Read latency is exactly one cycle: at each rising edge, r_data <= contents of the register addressed by io_control.addr in that cycle.
- Out-of-range addresses read 0.
- STATUS reads reflect pre-edge state.
- Reads have no side effects; enable is not required for a read.
REQ-017 FIFO: circular buffer with wrapping read/write pointers. Count is updated as count + accepted write - pop. Pointers wrap to 0 after fifo_depth-1.
REQ-018 FSM states IDLE, START, DATA, STOP. Bit counter 0..7 and baud counter 16 bits.
REQ-019 IDLE: tx=1. At an edge with FIFO non-empty, pop the head into a shift register, load the baud counter with divisor-1, and go to START.
REQ-020 START: tx=0 for divisor cycles, then DATA with bit index 0.
REQ-021 DATA: tx = shift[0] for divisor cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
REQ-022 STOP: tx=1 for divisor cycles, then IDLE. The next pop can occur on the edge leaving STOP's last cycle, i.e. frames are back-to-back with no extra idle cycle. The FSM goes STOP->START directly if the FIFO is non-empty.
REQ-023 tx is driven from a register, never combinationally.
REQ-024 A DIVISOR write mid-frame affects only bit periods whose baud counter reloads after the write edge; the current bit keeps its length.
REQ-025 Latency: TXDATA write at edge k into an empty FIFO with FSM IDLE gives pop at edge k+1 and tx=0 from edge k+1. Each frame is 10*divisor cycles.
REQ-026 Simultaneous write and pop with count=1 leaves count=1 and empty=0 throughout.

Reset
REQ-027 While reset_n=0, all state is forced asynchronously: tx=1, r_data=0, FSM=IDLE, count=0, pointers=0, overflow=0, divisor=reset_divisor, shift register=0.
REQ-028 Reset asserted mid-frame aborts the frame immediately (tx=1) and discards FIFO contents.
REQ-029 After reset_n rises, the first edge behaves as normal operation.

Verification
REQ-030 divisor=4, write 0x55 to TXDATA at edge k: tx low for edges k+1..k+4, then bits 1,0,1,0,1,0,1,0 (4 cycles each), stop high 4 cycles, STATUS=0x0000_0002 at end.
REQ-031 divisor=2, write 9 bytes back-to-back to TXDATA while FSM busy: first byte popped, remaining 8 fill FIFO, all 9 transmitted. With 10 writes (one dropped) STATUS bit3=1. Write STATUS value 0x8: bit3 clears.
REQ-032 Read latency: addr=base+0x8 in cycle k after writing 0x0123: r_data=0x0000_0123 after edge k+1. Addr base+0xC: r_data=0.
REQ-033 Full FIFO (count=8) with FSM popping same cycle as a TXDATA write: write accepted, count stays 8, overflow stays 0.
REQ-034 Assert reset_n=0 during DATA bit 3: tx=1 without a clock edge. After release, STATUS=0x0000_0002 and DIVISOR reads 868.
REQ-035 Write DIVISOR=0 then 0xA5: each bit lasts 1 cycle, frame is 10 cycles total.
